lag_pl_buffers_cr: RTL and testbench
====================================

Name: lag_pl_buffers_cr

Overview:
- Second-generation physical-lane (PL) buffer bank for the LAG router input port: `n` independent lane FIFOs with independently parameterised width and depth.
- Adds behaviour the previous bank lacked: per-lane occupancy counters, nearly-full/nearly-empty flags, registered credit-return pulses to the upstream router, and sticky overflow/underflow error flags.
- Sits between the link input decoder (which drives push) and the switch allocator (which drives pop).

Parameters:
- n, 4, number of physical lanes (≥1)
- size, 3, entries per lane FIFO (≥2)
- width, 64, flit width in bits
- nf_thresh, 1, nearly_full asserted when free entries ≤ nf_thresh
- ne_thresh, 1, nearly_empty asserted when occupancy ≤ ne_thresh

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, asynchronous active-low reset
- push  in  n  per-lane write strobe
- pop  in  n  per-lane read strobe
- data_in  in  n*width  lane i flit at [i*width +: width]
- data_out  out  n*width  head flit of lane i (first-word fall-through)
- full  out  n  lane holds size entries
- empty  out  n  lane holds 0 entries
- nearly_full  out  n  see nf_thresh
- nearly_empty  out  n  see ne_thresh
- occupancy  out  n*cw  entry count per lane; cw = $clog2(size+1)
- credit_out  out  n  one-cycle credit pulse per accepted pop
- clr_err  in  1  synchronous clear of all sticky error flags
- overflow_err  out  n  sticky: push refused because lane was full
- underflow_err  out  n  sticky: pop refused because lane was empty

Behaviour:
- Reset (async assert, sync deassert by the system) drives all outputs to idle:
  - occupancy=0, empty=all ones, full=0.
  - nearly_empty=all ones; nearly_full=0 unless size ≤ nf_thresh.
  - credit_out=0, errors=0, data_out=0.
  - Read/write pointers=0.
- Each lane is a circular buffer with rd_ptr and wr_ptr in 0..size-1. Pointers wrap explicitly, size need not be a power of 2.
- Occupancy counter per lane:
  - +1 on accepted push only; -1 on accepted pop only.
  - Unchanged on an accepted push+pop in the same cycle.
  - Flags are derived combinationally from the registered occupancy.
- Accepted push = push & (!full | accepted pop same cycle). A full lane accepts push+pop together: the entry is freed and rewritten, occupancy stays at size.
- Accepted pop = pop & !empty.
- Push on a full lane without pop: data dropped, state unchanged, overflow_err[i] set next cycle.
- Pop on an empty lane: ignored, underflow_err[i] set next cycle. Push in the same cycle is still accepted, except in bypass mode (see Optional Feature).
- data_out[i] = mem[rd_ptr]. Valid only while !empty; holds the last value (no X) when empty.
- Write latency: a flit pushed in cycle t is visible at data_out in cycle t+1 if the lane was empty.
- credit_out[i] is registered: high in cycle t+1 for each accepted pop in cycle t. Back-to-back pops give continuous high.
- Error flags:
  - Once set, held until clr_err.
  - When clr_err and a new error occur in the same cycle, the flag stays set (set wins).
- Lanes are fully independent. No arbitration inside the block.

Optional Feature:
- Macro: LAG_PL_BYPASS_EN
- Defined:
  - When a lane is empty, data_out[i] = data_in[i] combinationally.
  - A push and pop in the same cycle on an empty lane is accepted as a pass-through: no write, occupancy stays 0, credit_out pulses next cycle, no underflow.
- Undefined:
  - No combinational input-to-output path.
  - Pop on an empty lane is always an underflow.

Decomposition:
- Package lag_pl_pkg holds:
  - a fifov_flags_t struct (full, empty, nearly_full, nearly_empty)
  - the function cw_of(size) returning $clog2(size+1)
  - the error-flag enum used by the monitor.
- One sub-module, lag_pl_lane_fifo: a single lane with pointers, counter, flags, credit register and error bits. The top generates n instances.

Test Plan (n=4, size=3, width=8, thresholds 1):
- Reset mid-traffic:
  - Stimulus: lane0 holds 2 flits; rst_n low.
  - Required response: within the same cycle occupancy=0, empty=4'b1111, credit_out=0, errors=0. After release, a push of 0xA5 appears on data_out[0] next cycle.
- Fill and overflow:
  - Stimulus: push 0x11, 0x22, 0x33, 0x44 on lane2 in consecutive cycles.
  - Required response: full[2]=1 after the 3rd push; 0x44 dropped; overflow_err[2]=1; pops return 0x11, 0x22, 0x33.
- Full with simultaneous push+pop:
  - Stimulus: full lane1; push 0x55 with pop.
  - Required response: occupancy stays 3, credit_out[1] pulses once, overflow_err[1]=0, 0x55 is popped 3rd.
- Wrap-around:
  - Stimulus: 10 interleaved push/pop pairs on lane3 with data 0..9.
  - Required response: output order 0..9; pointers wrap at 3; occupancy never exceeds 1.
- Underflow and clear:
  - Stimulus: pop on empty lane0.
  - Required response: underflow_err[0]=1 (bypass off). clr_err alone clears it; clr_err plus a new underflow keeps it at 1.
- Bypass (LAG_PL_BYPASS_EN defined):
  - Stimulus: empty lane0; push 0x7E with pop.
  - Required response: data_out[0]=0x7E in the same cycle; occupancy remains 0; credit_out[0]=1 next cycle.

Source files
------------

// File: rtl/lag_pl_pkg.sv
// Shared types and helpers for the LAG physical-lane buffer bank.
// Optional feature macro used by the bank: LAG_PL_BYPASS_EN.
package lag_pl_pkg;

  typedef struct packed {
    logic full;
    logic empty;
    logic nearly_full;
    logic nearly_empty;
  } fifov_flags_t;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_OVERFLOW,
    ERR_UNDERFLOW
  } pl_err_e;

  function automatic int cw_of(input int size);
    return $clog2(size + 1);
  endfunction

endpackage

// File: rtl/lag_pl_lane_fifo.sv
// One physical-lane FIFO: circular buffer, occupancy counter, flags, credit pulse, sticky errors.
// LAG_PL_BYPASS_EN enables empty-lane pass-through (data_in straight to data_out).
module lag_pl_lane_fifo
  import lag_pl_pkg::*;
#(
  parameter int size      = 3,
  parameter int width     = 64,
  parameter int nf_thresh = 1,
  parameter int ne_thresh = 1,
  parameter int cw        = cw_of(size)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clr_err,
  input  logic [width-1:0] data_in,
  output logic [width-1:0] data_out,
  output fifov_flags_t     flags,
  output logic [cw-1:0]    occupancy,
  output logic             credit_out,
  output logic             overflow_err,
  output logic             underflow_err
);

  localparam int pw = (size > 1) ? $clog2(size) : 1;

  logic [width-1:0] mem [size];
  logic [pw-1:0]    rd_ptr, wr_ptr;
  logic [cw-1:0]    occ;
  logic             empty_w, full_w, acc_push, acc_pop, pass;
  pl_err_e          err_ev;

  function automatic logic [pw-1:0] ptr_next(input logic [pw-1:0] p);
    return (p == pw'(size - 1)) ? '0 : p + 1'b1;
  endfunction

  // A full lane still takes a push when the same cycle frees its head entry.
  always_comb begin
    empty_w = (occ == '0);
    full_w  = (occ == cw'(size));
`ifdef LAG_PL_BYPASS_EN
    pass    = push & pop & empty_w;
`else
    pass    = 1'b0;
`endif
    acc_pop  = pop & ~empty_w;
    acc_push = push & (~full_w | acc_pop) & ~pass;
    err_ev   = ERR_NONE;
    if (push & full_w & ~acc_pop)
      err_ev = ERR_OVERFLOW;
    else if (pop & empty_w & ~pass)
      err_ev = ERR_UNDERFLOW;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < size; i++) mem[i] <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      occ           <= '0;
      credit_out    <= 1'b0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (acc_push) begin
        mem[wr_ptr] <= data_in;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (acc_pop) rd_ptr <= ptr_next(rd_ptr);
      if (acc_push && !acc_pop)
        occ <= occ + 1'b1;
      else if (acc_pop && !acc_push)
        occ <= occ - 1'b1;
      credit_out <= acc_pop | pass;
      // A new error in the clearing cycle keeps the flag set.
      overflow_err  <= (err_ev == ERR_OVERFLOW)  | (overflow_err  & ~clr_err);
      underflow_err <= (err_ev == ERR_UNDERFLOW) | (underflow_err & ~clr_err);
    end
  end

  always_comb begin
    occupancy          = occ;
    flags.full         = full_w;
    flags.empty        = empty_w;
    flags.nearly_full  = (32'(size) - 32'(occ)) <= 32'(nf_thresh);
    flags.nearly_empty = 32'(occ) <= 32'(ne_thresh);
`ifdef LAG_PL_BYPASS_EN
    data_out = empty_w ? data_in : mem[rd_ptr];
`else
    data_out = mem[rd_ptr];
`endif
  end

endmodule

// File: rtl/lag_pl_buffers_cr.sv
// LAG router input-port PL buffer bank: n independent lane FIFOs with credit return.
// Define LAG_PL_BYPASS_EN to enable the empty-lane pass-through path.
module lag_pl_buffers_cr
  import lag_pl_pkg::*;
#(
  parameter int n         = 4,
  parameter int size      = 3,
  parameter int width     = 64,
  parameter int nf_thresh = 1,
  parameter int ne_thresh = 1,
  parameter int cw        = cw_of(size)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [n-1:0]     push,
  input  logic [n-1:0]     pop,
  input  logic [n*width-1:0] data_in,
  output logic [n*width-1:0] data_out,
  output logic [n-1:0]     full,
  output logic [n-1:0]     empty,
  output logic [n-1:0]     nearly_full,
  output logic [n-1:0]     nearly_empty,
  output logic [n*cw-1:0]  occupancy,
  output logic [n-1:0]     credit_out,
  input  logic             clr_err,
  output logic [n-1:0]     overflow_err,
  output logic [n-1:0]     underflow_err
);

  for (genvar i = 0; i < n; i++) begin : g_lane
    fifov_flags_t lane_flags;

    lag_pl_lane_fifo #(
      .size      (size),
      .width     (width),
      .nf_thresh (nf_thresh),
      .ne_thresh (ne_thresh),
      .cw        (cw)
    ) u_lane (
      .clk           (clk),
      .rst_n         (rst_n),
      .push          (push[i]),
      .pop           (pop[i]),
      .clr_err       (clr_err),
      .data_in       (data_in[i*width +: width]),
      .data_out      (data_out[i*width +: width]),
      .flags         (lane_flags),
      .occupancy     (occupancy[i*cw +: cw]),
      .credit_out    (credit_out[i]),
      .overflow_err  (overflow_err[i]),
      .underflow_err (underflow_err[i])
    );

    assign full[i]         = lane_flags.full;
    assign empty[i]        = lane_flags.empty;
    assign nearly_full[i]  = lane_flags.nearly_full;
    assign nearly_empty[i] = lane_flags.nearly_empty;
  end

endmodule

// File: tb/tb_lag_pl_buffers_cr.sv
// Directed self-checking bench for lag_pl_buffers_cr (n=4, size=3, width=8, thresholds 1).
// Bypass checks are compiled in when LAG_PL_BYPASS_EN is defined.
module tb_lag_pl_buffers_cr;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  push, pop;
  logic [N*W-1:0] data_in;
  logic [N*W-1:0] data_out;
  logic [N-1:0]  full, empty, nearly_full, nearly_empty, credit_out;
  logic [N*CW-1:0] occupancy;
  logic          clr_err;
  logic [N-1:0]  overflow_err, underflow_err;

  int compareCount  = 0;
  int mismatchCount = 0;

  lag_pl_buffers_cr #(
    .n(N), .size(3), .width(W), .nf_thresh(1), .ne_thresh(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .data_in(data_in),
    .data_out(data_out), .full(full), .empty(empty), .nearly_full(nearly_full),
    .nearly_empty(nearly_empty), .occupancy(occupancy), .credit_out(credit_out),
    .clr_err(clr_err), .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] headOf(input int lane);
    return data_out[lane*W +: W];
  endfunction

  function automatic logic [CW-1:0] occOf(input int lane);
    return occupancy[lane*CW +: CW];
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compareCount++;
    if (got !== exp) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] p, input logic [N-1:0] q,
                               input int lane, input logic [W-1:0] d);
    push = p;
    pop  = q;
    data_in[lane*W +: W] = d;
    @(posedge clk); #1;
    push = '0;
    pop  = '0;
  endtask

  initial begin
    rst_n   = 1'b0;
    push    = '0;
    pop     = '0;
    clr_err = 1'b0;
    data_in = '0;
    #1;
    checkOutput("rst_occ",     occupancy, 0);
    checkOutput("rst_empty",   empty, 4'hF);
    checkOutput("rst_full",    full, 0);
    checkOutput("rst_nempty",  nearly_empty, 4'hF);
    checkOutput("rst_nfull",   nearly_full, 0);
    checkOutput("rst_credit",  credit_out, 0);
    checkOutput("rst_errs",    {overflow_err, underflow_err}, 0);
    checkOutput("rst_dout",    data_out, 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of traffic
    applyStimulus(4'b0001, 4'b0000, 0, 8'h01);
    applyStimulus(4'b0001, 4'b0000, 0, 8'h02);
    checkOutput("mid_occ0",    occOf(0), 2);
    checkOutput("mid_nfull0",  nearly_full[0], 1);
    checkOutput("mid_nempty0", nearly_empty[0], 0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_occ",    occupancy, 0);
    checkOutput("arst_empty",  empty, 4'hF);
    checkOutput("arst_credit", credit_out, 0);
    checkOutput("arst_errs",   {overflow_err, underflow_err}, 0);
    #2 rst_n = 1'b1;
    applyStimulus(4'b0001, 4'b0000, 0, 8'hA5);
    checkOutput("post_rst_head", headOf(0), 8'hA5);
    checkOutput("post_rst_empty0", empty[0], 0);
    applyStimulus(4'b0000, 4'b0001, 0, 8'h00);
    checkOutput("pop_credit0", credit_out, 4'b0001);
    checkOutput("pop_empty0",  empty[0], 1);
    applyStimulus(4'b0000, 4'b0000, 0, 8'h00);
    checkOutput("credit_drop0", credit_out, 0);

    // Fill lane 2 and overflow it
    applyStimulus(4'b0100, 4'b0000, 2, 8'h11);
    applyStimulus(4'b0100, 4'b0000, 2, 8'h22);
    applyStimulus(4'b0100, 4'b0000, 2, 8'h33);
    checkOutput("fill_full2", full[2], 1);
    checkOutput("fill_occ2",  occOf(2), 3);
    applyStimulus(4'b0100, 4'b0000, 2, 8'h44);
    checkOutput("ovf_err",    overflow_err, 4'b0100);
    checkOutput("ovf_occ2",   occOf(2), 3);
    checkOutput("ovf_head11", headOf(2), 8'h11);
    applyStimulus(4'b0000, 4'b0100, 2, 8'h00);
    checkOutput("pop_head22", headOf(2), 8'h22);
    applyStimulus(4'b0000, 4'b0100, 2, 8'h00);
    checkOutput("pop_head33", headOf(2), 8'h33);
    checkOutput("b2b_credit2", credit_out, 4'b0100);
    applyStimulus(4'b0000, 4'b0100, 2, 8'h00);
    checkOutput("drain_empty2", empty[2], 1);
    checkOutput("ovf_sticky",   overflow_err[2], 1);
    clr_err = 1'b1;
    applyStimulus(4'b0000, 4'b0000, 2, 8'h00);
    clr_err = 1'b0;
    checkOutput("ovf_clear", overflow_err, 0);

    // Full lane 1 with simultaneous push and pop
    applyStimulus(4'b0010, 4'b0000, 1, 8'hA1);
    applyStimulus(4'b0010, 4'b0000, 1, 8'hA2);
    applyStimulus(4'b0010, 4'b0000, 1, 8'hA3);
    applyStimulus(4'b0010, 4'b0010, 1, 8'h55);
    checkOutput("pp_occ1",    occOf(1), 3);
    checkOutput("pp_credit1", credit_out[1], 1);
    checkOutput("pp_ovf1",    overflow_err[1], 0);
    checkOutput("pp_headA2",  headOf(1), 8'hA2);
    applyStimulus(4'b0000, 4'b0000, 1, 8'h00);
    checkOutput("pp_credit_once", credit_out[1], 0);
    applyStimulus(4'b0000, 4'b0010, 1, 8'h00);
    checkOutput("pp_headA3",  headOf(1), 8'hA3);
    applyStimulus(4'b0000, 4'b0010, 1, 8'h00);
    checkOutput("pp_head55",  headOf(1), 8'h55);
    applyStimulus(4'b0000, 4'b0010, 1, 8'h00);
    checkOutput("pp_empty1",  empty[1], 1);

    // Wrap-around on lane 3
    for (int k = 0; k < 10; k++) begin
      applyStimulus(4'b1000, 4'b0000, 3, 8'(k));
      checkOutput("wrap_head", headOf(3), 8'(k));
      checkOutput("wrap_occ1", occOf(3), 1);
      applyStimulus(4'b0000, 4'b1000, 3, 8'h00);
      checkOutput("wrap_occ0", occOf(3), 0);
    end

    // Underflow and clear on lane 0
    applyStimulus(4'b0000, 4'b0001, 0, 8'h00);
    checkOutput("udf_set",   underflow_err, 4'b0001);
    checkOutput("udf_nocredit", credit_out[0], 0);
    clr_err = 1'b1;
    applyStimulus(4'b0000, 4'b0000, 0, 8'h00);
    checkOutput("udf_clear", underflow_err, 0);
    applyStimulus(4'b0000, 4'b0001, 0, 8'h00);
    clr_err = 1'b0;
    checkOutput("udf_set_wins", underflow_err[0], 1);
    clr_err = 1'b1;
    applyStimulus(4'b0000, 4'b0000, 0, 8'h00);
    clr_err = 1'b0;
    checkOutput("udf_clear2", underflow_err, 0);

`ifdef LAG_PL_BYPASS_EN
    // Pass-through on an empty lane
    push = 4'b0001;
    pop  = 4'b0001;
    data_in[7:0] = 8'h7E;
    #1;
    checkOutput("byp_comb_head", headOf(0), 8'h7E);
    @(posedge clk); #1;
    push = '0;
    pop  = '0;
    checkOutput("byp_occ0",    occOf(0), 0);
    checkOutput("byp_credit0", credit_out[0], 1);
    checkOutput("byp_no_udf",  underflow_err[0], 0);
`else
    // Push+pop on an empty lane: push is kept, pop is an underflow
    applyStimulus(4'b0001, 4'b0001, 0, 8'h3C);
    checkOutput("nb_occ0",    occOf(0), 1);
    checkOutput("nb_head",    headOf(0), 8'h3C);
    checkOutput("nb_udf",     underflow_err[0], 1);
    checkOutput("nb_credit0", credit_out[0], 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
